// File: rtl/aes128_pkg.sv
// Shared AES-128 primitives: S-box, GF(2^8) doubling, one step of key expansion, FSM states.
// Used by the iterative encryptor and by the key scheduler.
package aes128_pkg;

  localparam int unsigned NR        = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } encState_t;

  localparam logic [0:255][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Derives round key i+1 from round key i; rcon is the constant for round i+1.
  function automatic logic [127:0] expandKey(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    t  = subWord({rk[23:0], rk[31:24]}) ^ {rcon, 24'h000000};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64]  ^ w0;
    w2 = rk[63:32]  ^ w1;
    w3 = rk[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes128_encrypt_iter_if.sv
// Ready/valid bundle for the iterative encryptor: plaintext/key in, ciphertext out.
interface aes128_encrypt_iter_if;
  logic         encEnable;
  logic         inReady;
  logic [127:0] dataToOperate;
  logic [127:0] keyToOperate;
  logic         opComplete;
  logic         outReady;
  logic [127:0] opRetValue;

  modport master (
    output encEnable, dataToOperate, keyToOperate, outReady,
    input  inReady, opComplete, opRetValue
  );

  modport slave (
    input  encEnable, dataToOperate, keyToOperate, outReady,
    output inReady, opComplete, opRetValue
  );
endinterface

// File: rtl/aes128_enc_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// isFinal skips MixColumns for the last round.
module aes128_enc_round_comb
  import aes128_pkg::*;
(
  input  logic [127:0] stIn,
  input  logic [127:0] roundKey,
  input  logic         isFinal,
  output logic [127:0] stOut
);

  logic [127:0] subbed;
  logic [127:0] shifted;
  logic [127:0] mixed;

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    subbed = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      subbed[127-8*i -: 8] = sbox(stIn[127-8*i -: 8]);
    end
  end

  // Byte 4c+r sits at row r, column c; row r rotates left by r columns.
  always_comb begin
    shifted = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = subbed[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mixed = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mixColumn(shifted[127-32*c -: 32]);
    end
  end

  assign stOut = (isFinal ? shifted : mixed) ^ roundKey;

endmodule

// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Build option AES128_ENC_ZEROIZE_EN clears state, round key and result on output handshake.
module aes128_encrypt_iter
  import aes128_pkg::*;
#(
  parameter int unsigned NR = aes128_pkg::NR  // only 10 is supported
) (
  input logic                 CLK,
  input logic                 RST,
  aes128_encrypt_iter_if.slave bus
);

  encState_t    state, nextState;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rkNext;
  logic [127:0] roundOut;
  logic [127:0] retValue;
  logic         lastRound;

  assign rkNext    = expandKey(rk, rcon);
  assign lastRound = (round == 4'(NR));

  aes128_enc_round_comb uRound (
    .stIn     (st),
    .roundKey (rkNext),
    .isFinal  (lastRound),
    .stOut    (roundOut)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.encEnable) nextState = BUSY;
      BUSY:    if (lastRound)     nextState = DONE;
      DONE:    if (bus.outReady)  nextState = IDLE;
      default:                    nextState = IDLE;
    endcase
  end

  assign bus.inReady    = (state == IDLE);
  assign bus.opComplete = (state == DONE);
  assign bus.opRetValue = retValue;

  // Inputs are only sampled on the accept edge, so later changes cannot leak in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st       <= '0;
      rk       <= '0;
      rcon     <= RCON_INIT;
      round    <= '0;
      retValue <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.encEnable) begin
            st    <= bus.dataToOperate ^ bus.keyToOperate;
            rk    <= bus.keyToOperate;
            rcon  <= RCON_INIT;
            round <= 4'd1;
          end
        end
        BUSY: begin
          st    <= roundOut;
          rk    <= rkNext;
          rcon  <= xtime(rcon);
          round <= round + 4'd1;
          if (lastRound) begin
            retValue <= roundOut;
            round    <= '0;
          end
        end
`ifdef AES128_ENC_ZEROIZE_EN
        DONE: begin
          if (bus.outReady) begin
            st       <= '0;
            rk       <= '0;
            retValue <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
